clock_switch_ctrl: RTL and testbench
====================================

Name: clock_switch_ctrl

Overview:
Sequencer upstream of the 68060 clock generator. Owns that generator's ratio select (clk_select) and its active-low reset, plus the CPU reset line. It applies a software-requested CPU/bus clock ratio glitch-free: hold CPU in reset, stop the generator, change select, restart, then release CPU reset phase-aligned to nCLKEN. Also runs the same sequence once automatically after power-on/reset.

Parameters:
DEFAULT_SEL, 1'b0, clk_select value applied by the power-on sequence
PRE_HOLD, 16, in_clk cycles CPU reset is held before the generator is stopped (request path only)
GEN_STOP, 8, in_clk cycles gen_reset_n is held low; select changes on the first of these
SETTLE, 64, in_clk cycles after generator restart before alignment starts
ALIGN_TIMEOUT, 32, max in_clk cycles to wait for alignment (only with the optional feature)

Ports:
in_clk  input  1  system clock; same clock as the clock generator
reset  input  1  synchronous, active-low; sampled on posedge in_clk
req_valid  input  1  ratio-change request
req_sel  input  1  requested clk_select value
req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready
done  output  1  one-cycle pulse when a sequence completes
busy  output  1  high in any state other than IDLE
clk_select  output  1  to clock generator ratio select
gen_reset_n  output  1  to clock generator reset (active-low)
cpu_reset_n  output  1  to 68060 reset (active-low)
nclken_reg  input  1  registered nCLKEN phase from the clock generator
align_err  output  1  sticky; alignment timed out (0 when the feature is absent)

Behaviour:
- All outputs registered. While reset=0: state=STOP_GEN (power-on entry), clk_select=DEFAULT_SEL, gen_reset_n=0, cpu_reset_n=0, done=0, busy=1, req_ready=0, align_err=0, timer loaded with GEN_STOP-1.
- States: IDLE, PRE_HOLD, STOP_GEN, RESTART, ALIGN, RELEASE.
- IDLE: cpu_reset_n=1, gen_reset_n=1. Accepted request with req_sel != clk_select: latch req_sel, go to PRE_HOLD next cycle, cpu_reset_n=0 from that cycle. Accepted request with req_sel == clk_select: no reset activity; done pulses the next cycle; stay in IDLE.
- PRE_HOLD: PRE_HOLD cycles, then STOP_GEN.
- STOP_GEN: gen_reset_n=0 for GEN_STOP cycles. clk_select takes the latched value on the first STOP_GEN cycle, never while gen_reset_n=1. Then RESTART.
- RESTART: gen_reset_n=1, count SETTLE cycles, then ALIGN.
- ALIGN: track previous nclken_reg; on a falling edge (prev=1, now=0) go to RELEASE.
- RELEASE: cpu_reset_n=1 and done=1 for this cycle, then IDLE.
- Timer: a single down-counter of width $clog2(max(PRE_HOLD,GEN_STOP,SETTLE,ALIGN_TIMEOUT)+1). It is loaded with N-1 on state entry, and the state exits when the counter reaches 0. A parameter value of 0 is illegal and is caught by an elaboration assertion.
- req_valid outside IDLE is ignored; no queuing.
- Reset asserted mid-sequence: state and outputs return to reset values immediately on the next edge, and the power-on sequence restarts. Any latched request is discarded.
- Power-on sequence: STOP_GEN -> RESTART -> ALIGN -> RELEASE. It skips PRE_HOLD and pulses done at the end.

Optional Feature:
CLKSW_ALIGN_TIMEOUT_EN:
- Defined: ALIGN exits to RELEASE after ALIGN_TIMEOUT cycles without a falling edge, and sets align_err. align_err clears only on reset or on the next accepted request.
- Undefined: ALIGN waits indefinitely; align_err is tied 0; the ALIGN_TIMEOUT parameter is unused.

Decomposition:
- Package clock_switch_pkg: state enum (3-bit) and timer-width function/constant.
- One sub-module, clksw_timer: loadable down-counter with a zero flag.
- The FSM and edge detector stay in clock_switch_ctrl.

Test Plan:
- Power-on: reset low 5 cycles, then high; nclken_reg driven by a real clock generator instance.
  - gen_reset_n low for 8 cycles, then high.
  - cpu_reset_n rises on the first nclken falling edge at least 64 cycles later.
  - done pulses exactly once; clk_select=0.
- Ratio change 0->1: req_valid/req_sel=1 in IDLE.
  - req_ready drops the next cycle and cpu_reset_n=0 for at least 16+8+64 cycles.
  - clk_select changes only while gen_reset_n=0.
  - cpu_reset_n rises on an nclken falling edge; done=1 for 1 cycle.
- Same-select request (sel=1 while clk_select=1): done pulses the next cycle; cpu_reset_n and gen_reset_n stay 1.
- Request during busy (req_valid at RESTART cycle 10): ignored; clk_select is unchanged at completion.
- Reset pulled low at PRE_HOLD cycle 5: all outputs are at reset values on the next edge, and the power-on sequence reruns with clk_select=DEFAULT_SEL.
- With CLKSW_ALIGN_TIMEOUT_EN and nclken_reg stuck at 1: RELEASE occurs 32 cycles into ALIGN, align_err=1 and stays set until the next accepted request. Without the macro, the FSM remains in ALIGN after 1000 cycles.

Source files
------------

// File: rtl/clock_switch_pkg.sv
// Shared types and helpers for the clock ratio switch sequencer.
package clock_switch_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPreHold,
    StStopGen,
    StRestart,
    StAlign,
    StRelease
  } clksw_state_e;

  // Width of a down-counter that must hold the largest of the phase lengths.
  function automatic int unsigned clksw_timer_width(input int unsigned a, input int unsigned b,
                                                    input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clksw_timer.sv
// Loadable down-counter with zero flag; saturates at zero.
module clksw_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             in_clk,
  input  logic             load_i,
  input  logic [Width-1:0] value_i,
  output logic             zero_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - Width'(1);
    end
  end

  // No reset of its own: the owner forces a load while its reset is asserted.
  always_ff @(posedge in_clk) begin
    count_q <= count_d;
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/clock_switch_ctrl.sv
// Glitch-free CPU/bus clock ratio sequencer for the 68060 clock generator.
// Optional ALIGN timeout with sticky align_err: define CLKSW_ALIGN_TIMEOUT_EN.
module clock_switch_ctrl
  import clock_switch_pkg::*;
#(
  parameter logic        DEFAULT_SEL   = 1'b0,
  parameter int unsigned PRE_HOLD      = 16,
  parameter int unsigned GEN_STOP      = 8,
  parameter int unsigned SETTLE        = 64,
  parameter int unsigned ALIGN_TIMEOUT = 32
) (
  input  logic in_clk,
  input  logic reset,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  output logic done,
  output logic busy,
  output logic clk_select,
  output logic gen_reset_n,
  output logic cpu_reset_n,
  input  logic nclken_reg,
  output logic align_err
);

  localparam int unsigned TW = clksw_timer_width(PRE_HOLD, GEN_STOP, SETTLE, ALIGN_TIMEOUT);

  if (PRE_HOLD == 0 || GEN_STOP == 0 || SETTLE == 0 || ALIGN_TIMEOUT == 0) begin : g_bad_param
    $error("clock_switch_ctrl: timing parameters must be nonzero");
  end

  localparam logic [TW-1:0] PreLd = TW'(PRE_HOLD - 1);
  localparam logic [TW-1:0] GenLd = TW'(GEN_STOP - 1);
  localparam logic [TW-1:0] SetLd = TW'(SETTLE - 1);
  localparam logic [TW-1:0] AlnLd = TW'(ALIGN_TIMEOUT - 1);

  clksw_state_e state_q;
  logic sel_q, clk_select_q, gen_reset_n_q, cpu_reset_n_q, done_q, busy_q, req_ready_q;
  logic nclken_q, nclken_fall, align_timeout;
  logic tmr_load, tmr_zero;
  logic [TW-1:0] tmr_val;

  always_ff @(posedge in_clk) begin
    nclken_q <= nclken_reg;
  end

  assign nclken_fall = nclken_q & ~nclken_reg;

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = GenLd;
    if (!reset) begin
      tmr_load = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid && (req_sel != clk_select_q)) begin
            tmr_load = 1'b1;
            tmr_val  = PreLd;
          end
        end
        StPreHold: begin
          tmr_load = tmr_zero;
          tmr_val  = GenLd;
        end
        StStopGen: begin
          tmr_load = tmr_zero;
          tmr_val  = SetLd;
        end
        StRestart: begin
          tmr_load = tmr_zero;
          tmr_val  = AlnLd;
        end
        default: ;
      endcase
    end
  end

  clksw_timer #(
    .Width(TW)
  ) u_timer (
    .in_clk (in_clk),
    .load_i (tmr_load),
    .value_i(tmr_val),
    .zero_o (tmr_zero)
  );

`ifdef CLKSW_ALIGN_TIMEOUT_EN
  logic align_err_q;

  assign align_timeout = tmr_zero;

  always_ff @(posedge in_clk) begin
    if (!reset) begin
      align_err_q <= 1'b0;
    end else if (state_q == StIdle && req_valid) begin
      align_err_q <= 1'b0;
    end else if (state_q == StAlign && !nclken_fall && tmr_zero) begin
      align_err_q <= 1'b1;
    end
  end

  assign align_err = align_err_q;
`else
  assign align_timeout = 1'b0;
  assign align_err     = 1'b0;
`endif

  always_ff @(posedge in_clk) begin
    if (!reset) begin
      state_q       <= StStopGen;
      sel_q         <= DEFAULT_SEL;
      clk_select_q  <= DEFAULT_SEL;
      gen_reset_n_q <= 1'b0;
      cpu_reset_n_q <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b1;
      req_ready_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            if (req_sel != clk_select_q) begin
              sel_q         <= req_sel;
              state_q       <= StPreHold;
              cpu_reset_n_q <= 1'b0;
              busy_q        <= 1'b1;
              req_ready_q   <= 1'b0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StPreHold: begin
          if (tmr_zero) begin
            // Select changes on the same edge the generator is stopped.
            state_q       <= StStopGen;
            gen_reset_n_q <= 1'b0;
            clk_select_q  <= sel_q;
          end
        end
        StStopGen: begin
          if (tmr_zero) begin
            state_q       <= StRestart;
            gen_reset_n_q <= 1'b1;
          end
        end
        StRestart: begin
          if (tmr_zero) state_q <= StAlign;
        end
        StAlign: begin
          if (nclken_fall || align_timeout) begin
            state_q       <= StRelease;
            cpu_reset_n_q <= 1'b1;
            done_q        <= 1'b1;
          end
        end
        StRelease: begin
          state_q     <= StIdle;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q       <= StStopGen;
          gen_reset_n_q <= 1'b0;
          cpu_reset_n_q <= 1'b0;
          busy_q        <= 1'b1;
          req_ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign clk_select  = clk_select_q;
  assign gen_reset_n = gen_reset_n_q;
  assign cpu_reset_n = cpu_reset_n_q;

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Self-checking bench for clock_switch_ctrl with a behavioural clock generator model.
module tb_clock_switch_ctrl;

  logic in_clk = 1'b0;
  logic reset = 1'b0;
  logic req_valid = 1'b0;
  logic req_sel = 1'b0;
  logic nclken_reg = 1'b1;
  logic req_ready, done, busy, clk_select, gen_reset_n, cpu_reset_n, align_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit stuck = 1'b0;
  bit cur = 1'b0;
  logic [3:0] gcnt = '0;

  always #5 in_clk = ~in_clk;

  clock_switch_ctrl #(
    .DEFAULT_SEL  (1'b0),
    .PRE_HOLD     (16),
    .GEN_STOP     (8),
    .SETTLE       (64),
    .ALIGN_TIMEOUT(32)
  ) dut (
    .in_clk     (in_clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_sel    (req_sel),
    .req_ready  (req_ready),
    .done       (done),
    .busy       (busy),
    .clk_select (clk_select),
    .gen_reset_n(gen_reset_n),
    .cpu_reset_n(cpu_reset_n),
    .nclken_reg (nclken_reg),
    .align_err  (align_err)
  );

  // Clock generator model: nCLKEN divides by 2 (sel=0) or 4 (sel=1), held high in reset.
  always @(posedge in_clk) begin
    if (!gen_reset_n) begin
      gcnt       <= '0;
      nclken_reg <= 1'b1;
    end else begin
      gcnt       <= gcnt + 4'd1;
      nclken_reg <= stuck ? 1'b1 : (clk_select ? gcnt[1] : gcnt[0]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step;
    @(posedge in_clk);
    #1;
    cyc++;
  endtask

  // Output bundle order: gen_reset_n, cpu_reset_n, clk_select, done, busy, req_ready.
  task automatic expect_out(input string name, input logic gen, input logic cpu, input logic sel,
                            input logic dn, input logic bsy, input logic rdy);
    chk(name, {26'd0, gen_reset_n, cpu_reset_n, clk_select, done, busy, req_ready},
        {26'd0, gen, cpu, sel, dn, bsy, rdy});
  endtask

  task automatic issue_req(input bit sel);
    chk("req_ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_sel   = sel;
    step();
    req_valid = 1'b0;
  endtask

  // Walks one full sequence from its first cycle to the first IDLE cycle.
  task automatic check_seq(input bit with_pre, input bit old_sel, input bit new_sel,
                           input bit poke, input bit hang);
    bit prev, now, rel, tmo;
    prev = 1'b0;
    rel  = 1'b0;
    tmo  = 1'b0;
    if (with_pre) begin
      for (int i = 0; i < 16; i++) begin
        expect_out("pre_hold", 1, 0, old_sel, 0, 1, 0);
        step();
      end
    end
    for (int i = 0; i < 8; i++) begin
      expect_out("stop_gen", 0, 0, new_sel, 0, 1, 0);
      step();
    end
    for (int i = 0; i < 64; i++) begin
      expect_out("restart", 1, 0, new_sel, 0, 1, 0);
      if (poke && i == 10) begin
        req_valid = 1'b1;
        req_sel   = ~new_sel;
      end
      prev = nclken_reg;
      step();
      req_valid = 1'b0;
    end
    for (int k = 0; k < (hang ? 1000 : 200); k++) begin
      now = nclken_reg;
      expect_out("align", 1, 0, new_sel, 0, 1, 0);
      if (prev && !now) rel = 1'b1;
`ifdef CLKSW_ALIGN_TIMEOUT_EN
      else if (k == 31) tmo = 1'b1;
`endif
      prev = now;
      step();
      if (rel || tmo) break;
    end
    if (hang) begin
      chk("align_hang_no_release", {31'd0, rel | tmo}, 32'd0);
      return;
    end
    if (!(rel || tmo)) begin
      chk("align_budget_expired", 32'd0, 32'd1);
      return;
    end
    expect_out("release", 1, 1, new_sel, 1, 1, 0);
    chk("release_align_err", {31'd0, align_err}, {31'd0, tmo});
    step();
    expect_out("idle_after_seq", 1, 1, new_sel, 0, 0, 1);
  endtask

  typedef struct {
    bit sel;
    bit poke;
    bit full;
    bit exp_sel;
  } vec_t;

  vec_t tbl[5];

  initial begin : main
    bit sel, poke;
    int gap;
    tbl[0] = '{sel: 1'b1, poke: 1'b0, full: 1'b1, exp_sel: 1'b1};
    tbl[1] = '{sel: 1'b1, poke: 1'b0, full: 1'b0, exp_sel: 1'b1};
    tbl[2] = '{sel: 1'b0, poke: 1'b1, full: 1'b1, exp_sel: 1'b0};
    tbl[3] = '{sel: 1'b0, poke: 1'b0, full: 1'b0, exp_sel: 1'b0};
    tbl[4] = '{sel: 1'b1, poke: 1'b0, full: 1'b1, exp_sel: 1'b1};

    // Power-on
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out("reset_values", 0, 0, 0, 0, 1, 0);
      chk("reset_align_err", {31'd0, align_err}, 32'd0);
    end
    reset = 1'b1;
    check_seq(0, 0, 0, 0, 0);
    cur = 1'b0;

    for (int t = 0; t < 5; t++) begin
      issue_req(tbl[t].sel);
      if (tbl[t].full) begin
        check_seq(1, cur, tbl[t].sel, tbl[t].poke, 0);
      end else begin
        expect_out("same_sel_done", 1, 1, cur, 1, 0, 1);
        step();
        expect_out("same_sel_after", 1, 1, cur, 0, 0, 1);
      end
      chk("tbl_final_sel", {31'd0, clk_select}, {31'd0, tbl[t].exp_sel});
      cur = tbl[t].exp_sel;
    end

    // Reset in PRE_HOLD cycle 5 discards the pending switch to 0 and reruns power-on.
    issue_req(1'b0);
    for (int i = 0; i < 5; i++) begin
      expect_out("pre_hold_before_reset", 1, 0, 1, 0, 1, 0);
      step();
    end
    reset = 1'b0;
    step();
    expect_out("mid_seq_reset_values", 0, 0, 0, 0, 1, 0);
    chk("mid_seq_reset_align_err", {31'd0, align_err}, 32'd0);
    step();
    reset = 1'b1;
    check_seq(0, 0, 0, 0, 0);
    cur = 1'b0;

    // Randomised requests against the sequence model.
    for (int r = 0; r < 6; r++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        expect_out("idle_gap", 1, 1, cur, 0, 0, 1);
        step();
      end
      sel  = 1'($urandom_range(0, 1));
      poke = 1'($urandom_range(0, 1));
      issue_req(sel);
      if (sel != cur) begin
        check_seq(1, cur, sel, poke, 0);
      end else begin
        expect_out("rand_same_sel_done", 1, 1, cur, 1, 0, 1);
        step();
      end
      cur = sel;
      chk("rand_final_sel", {31'd0, clk_select}, {31'd0, cur});
    end

    // nCLKEN stuck high during ALIGN.
    stuck = 1'b1;
    issue_req(~cur);
`ifdef CLKSW_ALIGN_TIMEOUT_EN
    check_seq(1, cur, ~cur, 0, 0);
    cur = ~cur;
    stuck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("align_err_sticky", {31'd0, align_err}, 32'd1);
      step();
    end
    issue_req(cur);
    chk("align_err_cleared", {31'd0, align_err}, 32'd0);
    expect_out("clear_same_sel_done", 1, 1, cur, 1, 0, 1);
`else
    check_seq(1, cur, ~cur, 0, 1);
    chk("align_err_tied_low", {31'd0, align_err}, 32'd0);
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    stuck = 1'b0;
    check_seq(0, 0, 0, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
